vmicro16_uart_rx: RTL and testbench
===================================

VMICRO16_UART_RX -- requirements
Module: vmicro16_uart_rx

Interface
REQ-001 Parameter CLK_HZ, default 50000000, SHALL give the system clock frequency in Hz.
REQ-002 Parameter BAUD, default 115200, SHALL give the line bit rate.
REQ-003 Parameter FIFO_DEPTH, default 4, SHALL give the receive FIFO depth; it SHALL be a power of two, 2 or greater.
REQ-004 clk  input  1  SHALL be the single clock; all logic SHALL be rising-edge triggered.
REQ-005 reset_n  input  1  SHALL be an asynchronous, active-low reset.
REQ-006 uart_rx  input  1  SHALL be the asynchronous serial line, idle high, 8N1, LSB first.
REQ-007 S_PADDR  input  16  SHALL be the APB address; only bits [1:0] SHALL be decoded.
REQ-008 S_PSELx, S_PENABLE, S_PWRITE  input  1 each  SHALL be the APB select, enable and write strobes.
REQ-009 S_PWDATA  input  16  SHALL be the APB write data.
REQ-010 S_PRDATA  output  16  SHALL be the APB read data, registered.
REQ-011 S_PREADY  output  1  SHALL be tied high (zero wait states).
REQ-012 irq  output  1  SHALL be high whenever the FIFO is non-empty.

Function
REQ-013 uart_rx SHALL pass through a 2-flop synchronizer before any use; both flops SHALL reset to 1.
REQ-014 CPB (clocks per bit) SHALL be CLK_HZ/BAUD with integer truncation; HALF SHALL be CPB/2.
REQ-015 FSM states SHALL be IDLE, START, DATA, STOP, WAIT_HIGH; the bit-timing counter SHALL clear on every state entry.
REQ-016 IDLE: a synchronized low SHALL move the FSM to START.
REQ-017 START: at counter HALF-1, a low line SHALL move the FSM to DATA; a high line SHALL return it to IDLE as a rejected glitch.
REQ-018 DATA: every CPB clocks the line SHALL be sampled into bit index 0..7, LSB first; after bit 7 the FSM SHALL move to STOP.
REQ-019 STOP: after CPB clocks, a high sample SHALL push the byte and return to IDLE immediately, so back-to-back frames are accepted.
REQ-020 STOP: a low sample SHALL discard the byte, set sticky FE, and move to WAIT_HIGH.
REQ-021 WAIT_HIGH SHALL return to IDLE on the first synchronized high, so a break condition produces exactly one FE event.
REQ-022 Push when full SHALL drop the new byte, set sticky OVR, and leave the FIFO unchanged.
REQ-023 The FIFO SHALL be circular with wrap-around pointers and a count 0..FIFO_DEPTH.
REQ-024 Simultaneous push and pop SHALL perform both and leave count unchanged; this holds when full and when empty with a pop request.
REQ-025 APB access SHALL occur when S_PSELx & S_PENABLE; S_PRDATA SHALL be updated in that cycle and hold its value otherwise.
REQ-026 Read at 0x0 (DATA) SHALL return {8'h00, head byte} and pop one entry; reading when empty SHALL return 0x0000 with no pop.
REQ-027 Read at 0x1 (STATUS) SHALL return bit0 not-empty, bit1 full, bit2 OVR, bit3 FE, and zeros in bits [15:4].
REQ-028 Write to 0x1 SHALL clear OVR when S_PWDATA[2]=1 and clear FE when S_PWDATA[3]=1; a same-cycle set event SHALL take priority over the clear.
REQ-029 Reads of unmapped addresses SHALL return 0x0000; writes to 0x0 and to unmapped addresses SHALL be ignored.
REQ-030 Latency SHALL be: the byte is readable on the cycle after the stop-bit sample; irq SHALL rise in that same cycle.

Reset
REQ-031 Assertion of reset_n SHALL immediately force FSM=IDLE, counters=0, FIFO empty, OVR=FE=0, S_PRDATA=0x0000, irq=0.
REQ-032 A frame in progress when reset asserts SHALL be discarded; after release, reception SHALL resume only on a new falling edge.

Verification (CLK_HZ=50e6, BAUD=115200, CPB=434)
REQ-033 Receive 0xA5 -> STATUS=0x0001 and irq=1; DATA read=0x00A5; STATUS=0x0000 and irq=0 afterwards.
REQ-034 Drive a 100-clock low pulse on an idle line -> no push, STATUS=0x0000, FSM back in IDLE.
REQ-035 Send 0x3C with a low stop bit held low for 2 bit times -> FE set once, STATUS=0x0008, FIFO empty; writing 0x0008 to STATUS -> 0x0000.
REQ-036 Send 0x01..0x05 with no reads -> STATUS=0x0007; DATA reads return 0x01, 0x02, 0x03, 0x04, then 0x0000.
REQ-037 FIFO full with a DATA read in the same cycle as a stop-bit push -> count stays 4, no OVR, read order preserved.
REQ-038 Assert reset_n low mid-way through DATA of a frame, then release and send 0x5A -> only 0x5A is received and STATUS shows no error flags.

Source files
------------

// File: rtl/vmicro16_uart_rx.sv
// APB-attached 8N1 UART receiver with a small circular receive FIFO.
// Status flags OVR (overrun) and FE (framing error) are sticky until cleared by a STATUS write.
module vmicro16_uart_rx #(
    parameter int unsigned CLK_HZ     = 50000000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        uart_rx,
    input  logic [15:0] S_PADDR,
    input  logic        S_PSELx,
    input  logic        S_PENABLE,
    input  logic        S_PWRITE,
    input  logic [15:0] S_PWDATA,
    output logic [15:0] S_PRDATA,
    output logic        S_PREADY,
    output logic        irq
);
    localparam int unsigned CPB    = CLK_HZ / BAUD;
    localparam int unsigned HALF   = CPB / 2;
    localparam int unsigned CNT_W  = $clog2(CPB + 1);
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned FCNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0]  CPB_M1  = CNT_W'(CPB - 1);
    localparam logic [CNT_W-1:0]  HALF_M1 = CNT_W'(HALF - 1);
    localparam logic [FCNT_W-1:0] FULL_CT = FCNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

    state_t             state;
    logic               rx_meta, rx_s;
    logic [CNT_W-1:0]   cnt;
    logic [2:0]         bit_idx;
    logic [7:0]         shift;
    logic [7:0]         mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [FCNT_W-1:0]  count;
    logic               ovr, fe;

    logic stop_done, push, fe_set, empty, full;
    logic access, rd_req, wr_req, pop_req, pop, bypass, wr_en, ovr_set;
    logic [1:0]  addr;
    logic [7:0]  head;
    logic [15:0] status;
    logic        unused_bits;

    assign unused_bits = ^{S_PADDR[15:2], S_PWDATA[15:4], S_PWDATA[1:0]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= uart_rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            case (state)
                IDLE: if (!rx_s) begin
                    state <= START;
                    cnt   <= '0;
                end
                START: if (cnt == HALF_M1) begin
                    cnt     <= '0;
                    bit_idx <= '0;
                    state   <= rx_s ? IDLE : DATA;
                end else cnt <= cnt + 1'b1;
                DATA: if (cnt == CPB_M1) begin
                    cnt            <= '0;
                    shift[bit_idx] <= rx_s;
                    bit_idx        <= bit_idx + 1'b1;
                    if (bit_idx == 3'd7) state <= STOP;
                end else cnt <= cnt + 1'b1;
                STOP: if (cnt == CPB_M1) begin
                    cnt   <= '0;
                    state <= rx_s ? IDLE : WAIT_HIGH;
                end else cnt <= cnt + 1'b1;
                WAIT_HIGH: if (rx_s) begin
                    state <= IDLE;
                    cnt   <= '0;
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign stop_done = (state == STOP) && (cnt == CPB_M1);
    assign push      = stop_done && rx_s;
    assign fe_set    = stop_done && !rx_s;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CT);
    assign addr    = S_PADDR[1:0];
    assign access  = S_PSELx && S_PENABLE;
    assign rd_req  = access && !S_PWRITE;
    assign wr_req  = access && S_PWRITE;
    assign pop_req = rd_req && (addr == 2'd0);
    assign pop     = pop_req && !empty;
    // An empty-FIFO read coinciding with a push takes the incoming byte directly, leaving count at 0.
    assign bypass  = pop_req && empty && push;
    assign head    = bypass ? shift : mem[rd_ptr];
    assign wr_en   = push && !bypass && (!full || pop);
    assign ovr_set = push && full && !pop;
    assign status  = {12'h000, fe, ovr, full, !empty};

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= shift;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            ovr      <= 1'b0;
            fe       <= 1'b0;
            S_PRDATA <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            if (ovr_set)                                  ovr <= 1'b1;
            else if (wr_req && addr == 2'd1 && S_PWDATA[2]) ovr <= 1'b0;
            if (fe_set)                                   fe  <= 1'b1;
            else if (wr_req && addr == 2'd1 && S_PWDATA[3]) fe  <= 1'b0;

            if (rd_req) begin
                case (addr)
                    2'd0:    S_PRDATA <= (pop || bypass) ? {8'h00, head} : '0;
                    2'd1:    S_PRDATA <= status;
                    default: S_PRDATA <= '0;
                endcase
            end
        end
    end

    assign irq      = !empty;
    assign S_PREADY = 1'b1;

endmodule

// File: tb/tb_vmicro16_uart_rx.sv
// Directed bench for vmicro16_uart_rx at 50 MHz / 115200 baud (434 clocks per bit).
module tb_vmicro16_uart_rx;
    localparam int CPB = 434;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        uart_rx;
    logic [15:0] S_PADDR, S_PWDATA, S_PRDATA;
    logic        S_PSELx, S_PENABLE, S_PWRITE, S_PREADY, irq;

    int          checks = 0;
    int          errors = 0;
    logic        irq_pre, irq_post;
    logic [15:0] rd, dummy;

    vmicro16_uart_rx #(.CLK_HZ(50000000), .BAUD(115200), .FIFO_DEPTH(4)) dut (
        .clk(clk), .reset_n(reset_n), .uart_rx(uart_rx),
        .S_PADDR(S_PADDR), .S_PSELx(S_PSELx), .S_PENABLE(S_PENABLE),
        .S_PWRITE(S_PWRITE), .S_PWDATA(S_PWDATA), .S_PRDATA(S_PRDATA),
        .S_PREADY(S_PREADY), .irq(irq)
    );

    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%04h expected=0x%04h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic apb_read(input logic [15:0] a, output logic [15:0] d);
        S_PADDR = a; S_PWRITE = 1'b0; S_PSELx = 1'b1; S_PENABLE = 1'b0;
        tick(1);
        S_PENABLE = 1'b1;
        tick(1);
        d = S_PRDATA;
        S_PSELx = 1'b0; S_PENABLE = 1'b0;
    endtask

    task automatic apb_write(input logic [15:0] a, input logic [15:0] v);
        S_PADDR = a; S_PWDATA = v; S_PWRITE = 1'b1; S_PSELx = 1'b1; S_PENABLE = 1'b0;
        tick(1);
        S_PENABLE = 1'b1;
        tick(1);
        S_PSELx = 1'b0; S_PENABLE = 1'b0; S_PWRITE = 1'b0;
    endtask

    // Frame line starts low just after edge 0; the stop sample lands on edge 4126.
    // rd_at >= 0 places a DATA read access on that edge.
    task automatic send_frame(input logic [7:0] b, input logic stop_val, input int stop_bits,
                              input int rd_at, output logic [15:0] rd_val);
        int total;
        int bn;
        total  = (9 + stop_bits) * CPB;
        rd_val = '0;
        for (int c = 0; c < total; c++) begin
            bn = c / CPB;
            if (bn == 0)      uart_rx = 1'b0;
            else if (bn <= 8) uart_rx = b[bn-1];
            else              uart_rx = stop_val;
            if (c == 4125) irq_pre  = irq;
            if (c == 4126) irq_post = irq;
            if (rd_at >= 0) begin
                if (c == rd_at - 2) begin
                    S_PADDR = 16'h0000; S_PWRITE = 1'b0; S_PSELx = 1'b1; S_PENABLE = 1'b0;
                end
                if (c == rd_at - 1) S_PENABLE = 1'b1;
                if (c == rd_at) begin
                    rd_val = S_PRDATA;
                    S_PSELx = 1'b0; S_PENABLE = 1'b0;
                end
            end
            tick(1);
        end
        uart_rx = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0; uart_rx = 1'b1;
        S_PADDR = '0; S_PWDATA = '0; S_PSELx = 1'b0; S_PENABLE = 1'b0; S_PWRITE = 1'b0;
        tick(5);
        check("rst_prdata", S_PRDATA, 16'h0000);
        check("rst_irq", 16'(irq), 16'h0000);
        check("pready", 16'(S_PREADY), 16'h0001);
        reset_n = 1'b1;
        tick(5);

        // Single byte, latency, unmapped accesses
        send_frame(8'hA5, 1'b1, 1, -1, dummy);
        check("lat_irq_before", 16'(irq_pre), 16'h0000);
        check("lat_irq_after", 16'(irq_post), 16'h0001);
        tick(5);
        check("a5_irq", 16'(irq), 16'h0001);
        apb_read(16'h0001, rd); check("a5_status", rd, 16'h0001);
        apb_read(16'h0002, rd); check("unmapped2", rd, 16'h0000);
        apb_read(16'h0003, rd); check("unmapped3", rd, 16'h0000);
        apb_write(16'h0000, 16'hFFFF);
        apb_read(16'h0001, rd); check("a5_status_kept", rd, 16'h0001);
        apb_read(16'h0000, rd); check("a5_data", rd, 16'h00A5);
        apb_read(16'h0001, rd); check("a5_status_after", rd, 16'h0000);
        check("a5_irq_after", 16'(irq), 16'h0000);
        apb_read(16'h0000, rd); check("empty_data", rd, 16'h0000);

        // Start-bit glitch
        uart_rx = 1'b0; tick(100); uart_rx = 1'b1; tick(400);
        apb_read(16'h0001, rd); check("glitch_status", rd, 16'h0000);
        check("glitch_idle", 16'(dut.state), 16'h0000);

        // Framing error with a held-low stop bit
        send_frame(8'h3C, 1'b0, 2, -1, dummy);
        tick(20);
        apb_read(16'h0001, rd); check("fe_status", rd, 16'h0008);
        check("fe_irq", 16'(irq), 16'h0000);
        apb_write(16'h0001, 16'h0008);
        apb_read(16'h0001, rd); check("fe_cleared", rd, 16'h0000);

        // Overrun: five bytes into a four-deep FIFO
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 1, -1, dummy);
        tick(5);
        apb_read(16'h0001, rd); check("ovr_status", rd, 16'h0007);
        check("ovr_irq", 16'(irq), 16'h0001);
        apb_write(16'h0001, 16'h0004);
        apb_read(16'h0001, rd); check("ovr_cleared", rd, 16'h0003);

        // Full FIFO: pop coincides with the stop-bit push
        send_frame(8'h06, 1'b1, 1, 4126, rd);
        check("coinc_data", rd, 16'h0001);
        tick(5);
        apb_read(16'h0001, rd); check("coinc_status", rd, 16'h0003);
        apb_read(16'h0000, rd); check("order_2", rd, 16'h0002);
        apb_read(16'h0000, rd); check("order_3", rd, 16'h0003);
        apb_read(16'h0000, rd); check("order_4", rd, 16'h0004);
        apb_read(16'h0000, rd); check("order_6", rd, 16'h0006);
        apb_read(16'h0000, rd); check("order_empty", rd, 16'h0000);
        apb_read(16'h0001, rd); check("order_status", rd, 16'h0000);

        // Reset mid-frame with a non-empty FIFO
        send_frame(8'h11, 1'b1, 1, -1, dummy);
        tick(5);
        apb_read(16'h0001, rd); check("pre_rst_status", rd, 16'h0001);
        uart_rx = 1'b0;
        tick(3 * CPB);
        reset_n = 1'b0;
        uart_rx = 1'b1;
        #2;
        check("midrst_prdata", S_PRDATA, 16'h0000);
        check("midrst_irq", 16'(irq), 16'h0000);
        tick(5);
        reset_n = 1'b1;
        tick(500);
        apb_read(16'h0001, rd); check("post_rst_status", rd, 16'h0000);
        send_frame(8'h5A, 1'b1, 1, -1, dummy);
        tick(5);
        apb_read(16'h0001, rd); check("5a_status", rd, 16'h0001);
        apb_read(16'h0000, rd); check("5a_data", rd, 16'h005A);
        apb_read(16'h0001, rd); check("5a_status_after", rd, 16'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
